// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : alu_seq_pkg                                        |
// | Description : Shared state encoding and ALUX opcode constants    |
// |               for the register-bank / ALUX sequencer.            |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package alu_seq_pkg;

    // Sequencer states
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] EXEC  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] WB    = 3'd5;

    // ALUX opcodes that this datapath relies on
    localparam logic [3:0] OPR_A   = 4'b0000;
    localparam logic [3:0] OPR_B   = 4'b0001;
    localparam logic [3:0] OPR_SUM = 4'b0010;
    localparam logic [3:0] OPR_SUB = 4'b0011;

    // reg_bank write mode: whole word
    localparam logic [1:0] ENDW_FULL = 2'b00;

    // True for the opcodes with a fixed, well-known meaning
    function automatic logic opr_is_basic(input logic [3:0] opr);
        return (opr == OPR_A) || (opr == OPR_B) ||
               (opr == OPR_SUM) || (opr == OPR_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_timeout.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : alu_seq_timeout                                    |
// | Description : Loadable down-counter with expiry flag, used to    |
// |               bound the wait for ALUX done.                      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module alu_seq_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expired
);

    localparam int                 c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_load_val = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Load TIMEOUT-1 at start, count down to zero and stick there
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : alu_sequencer                                      |
// | Description : Drives one register-to-register operation through |
// |               reg_bank read, ALUX execute and reg_bank write-back|
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DW      = 64,
    parameter int RSW     = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [3:0]     instr_opr,
    input  logic [RSW-1:0] instr_srcA,
    input  logic [RSW-1:0] instr_srcB,
    input  logic [RSW-1:0] instr_dst,
    input  logic           instr_cnstA,
    input  logic           instr_cnstB,
    input  logic           instr_wb,
    input  logic [1:0]     instr_endw,
    output logic [RSW-1:0] seloutA,
    output logic [RSW-1:0] seloutB,
    output logic           cnstA,
    output logic           cnstB,
    output logic           enrregA,
    output logic           enrregB,
    input  logic [DW-1:0]  outA,
    input  logic [DW-1:0]  outB,
    output logic           regwen,
    output logic [RSW-1:0] selwreg,
    output logic [1:0]     endwreg,
    output logic [DW-1:0]  wdata,
    output logic [DW-1:0]  alu_inA,
    output logic [DW-1:0]  alu_inB,
    output logic [3:0]     alu_opr,
    output logic           alu_start,
    input  logic [DW-1:0]  alu_result,
    input  logic           alu_done,
    output logic           res_valid,
    output logic [DW-1:0]  res_data,
    output logic           err,
    output logic           busy
);

    logic [2:0]     r_state;
    logic           r_ready;
    logic           r_busy;

    // Captured instruction fields needed after the read phase
    logic [3:0]     r_opr;
    logic [RSW-1:0] r_dst;
    logic           r_wb;
    logic [1:0]     r_endw;

    // Registered outputs
    logic [RSW-1:0] r_sela;
    logic [RSW-1:0] r_selb;
    logic           r_cnsta;
    logic           r_cnstb;
    logic           r_enra;
    logic           r_enrb;
    logic           r_regwen;
    logic [RSW-1:0] r_selwreg;
    logic [1:0]     r_endwreg;
    logic [DW-1:0]  r_wdata;
    logic [DW-1:0]  r_alu_ina;
    logic [DW-1:0]  r_alu_inb;
    logic [3:0]     r_alu_opr;
    logic           r_alu_start;
    logic           r_res_valid;
    logic [DW-1:0]  r_res_data;
    logic           r_err;

    logic           w_tmo_load;
    logic           w_tmo_dec;
    logic           w_tmo_expired;

    // Timer is armed on the cycle start is issued and runs only while waiting
    assign w_tmo_load = (r_state == EXEC);
    assign w_tmo_dec  = (r_state == WAIT);

    alu_seq_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_tmo_load),
        .i_dec     (w_tmo_dec),
        .o_expired (w_tmo_expired)
    );

    // Sequencer FSM; every output is updated on the edge that closes the
    // current state, so read selects appear on the accept edge and the
    // reg_bank's one-cycle output register is valid while in LATCH.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_opr       <= OPR_A;
            r_dst       <= '0;
            r_wb        <= 1'b0;
            r_endw      <= ENDW_FULL;
            r_sela      <= '0;
            r_selb      <= '0;
            r_cnsta     <= 1'b0;
            r_cnstb     <= 1'b0;
            r_enra      <= 1'b0;
            r_enrb      <= 1'b0;
            r_regwen    <= 1'b0;
            r_selwreg   <= '0;
            r_endwreg   <= ENDW_FULL;
            r_wdata     <= '0;
            r_alu_ina   <= '0;
            r_alu_inb   <= '0;
            r_alu_opr   <= OPR_A;
            r_alu_start <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            r_regwen    <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (instr_valid && r_ready) begin
                        r_opr   <= instr_opr;
                        r_dst   <= instr_dst;
                        r_wb    <= instr_wb;
                        r_endw  <= instr_endw;
                        r_sela  <= instr_srcA;
                        r_selb  <= instr_srcB;
                        r_cnsta <= instr_cnstA;
                        r_cnstb <= instr_cnstB;
                        r_enra  <= 1'b1;
                        r_enrb  <= 1'b1;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_enra  <= 1'b0;
                    r_enrb  <= 1'b0;
                    r_state <= LATCH;
                end
                LATCH: begin
                    r_alu_ina <= outA;
                    r_alu_inb <= outB;
                    r_state   <= EXEC;
                end
                EXEC: begin
                    r_alu_start <= 1'b1;
                    r_alu_opr   <= r_opr;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    // done takes priority over a coincident expiry
                    if (alu_done) begin
                        r_res_data  <= alu_result;
                        r_res_valid <= 1'b1;
                        if (r_wb) begin
                            r_regwen  <= 1'b1;
                            r_selwreg <= r_dst;
                            r_wdata   <= alu_result;
                            r_endwreg <= r_endw;
                            r_state   <= WB;
                        end else begin
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else if (w_tmo_expired) begin
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                WB: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign busy        = r_busy;
    assign seloutA     = r_sela;
    assign seloutB     = r_selb;
    assign cnstA       = r_cnsta;
    assign cnstB       = r_cnstb;
    assign enrregA     = r_enra;
    assign enrregB     = r_enrb;
    assign regwen      = r_regwen;
    assign selwreg     = r_selwreg;
    assign endwreg     = r_endwreg;
    assign wdata       = r_wdata;
    assign alu_inA     = r_alu_ina;
    assign alu_inB     = r_alu_inb;
    assign alu_opr     = r_alu_opr;
    assign alu_start   = r_alu_start;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_alu_sequencer                                   |
// | Description : Self-checking bench for alu_sequencer with a       |
// |               reg_bank model, a delayed ALUX model and a         |
// |               transaction-level reference.                       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int DW      = 64;
    localparam int RSW     = 4;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [3:0]     opr;
        logic [RSW-1:0] sa;
        logic [RSW-1:0] sb;
        logic [RSW-1:0] dst;
        logic           wb;
        logic           ca;
        logic           cb;
    } instr_t;

    logic           clock;
    logic           reset;
    logic           instr_valid;
    logic           instr_ready;
    logic [3:0]     instr_opr;
    logic [RSW-1:0] instr_srcA;
    logic [RSW-1:0] instr_srcB;
    logic [RSW-1:0] instr_dst;
    logic           instr_cnstA;
    logic           instr_cnstB;
    logic           instr_wb;
    logic [1:0]     instr_endw;
    logic [RSW-1:0] seloutA;
    logic [RSW-1:0] seloutB;
    logic           cnstA;
    logic           cnstB;
    logic           enrregA;
    logic           enrregB;
    logic [DW-1:0]  outA;
    logic [DW-1:0]  outB;
    logic           regwen;
    logic [RSW-1:0] selwreg;
    logic [1:0]     endwreg;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  alu_inA;
    logic [DW-1:0]  alu_inB;
    logic [3:0]     alu_opr;
    logic           alu_start;
    logic [DW-1:0]  alu_result;
    logic           alu_done;
    logic           res_valid;
    logic [DW-1:0]  res_data;
    logic           err;
    logic           busy;

    int n_asserts = 0;
    int n_fail    = 0;

    alu_sequencer #(
        .DW      (DW),
        .RSW     (RSW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_opr   (instr_opr),
        .instr_srcA  (instr_srcA),
        .instr_srcB  (instr_srcB),
        .instr_dst   (instr_dst),
        .instr_cnstA (instr_cnstA),
        .instr_cnstB (instr_cnstB),
        .instr_wb    (instr_wb),
        .instr_endw  (instr_endw),
        .seloutA     (seloutA),
        .seloutB     (seloutB),
        .cnstA       (cnstA),
        .cnstB       (cnstB),
        .enrregA     (enrregA),
        .enrregB     (enrregB),
        .outA        (outA),
        .outB        (outB),
        .regwen      (regwen),
        .selwreg     (selwreg),
        .endwreg     (endwreg),
        .wdata       (wdata),
        .alu_inA     (alu_inA),
        .alu_inB     (alu_inB),
        .alu_opr     (alu_opr),
        .alu_start   (alu_start),
        .alu_result  (alu_result),
        .alu_done    (alu_done),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .err         (err),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference ALUX behaviour
    function automatic logic [DW-1:0] ref_alu(input logic [3:0] opr,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (opr)
            OPR_A:   return a;
            OPR_B:   return b;
            OPR_SUM: return a + b;
            OPR_SUB: return a - b;
            default: return a;
        endcase
    endfunction

    // reg_bank model: output registers load on enrreg, one-cycle latency
    logic [DW-1:0]  bank [16];
    logic           pl_en  = 1'b0;
    logic [RSW-1:0] pl_idx = '0;
    logic [DW-1:0]  pl_val = '0;
    always @(posedge clock) begin
        if (pl_en)
            bank[pl_idx] <= pl_val;
        else if (regwen && endwreg == ENDW_FULL)
            bank[selwreg] <= wdata;
        if (enrregA) outA <= bank[seloutA];
        if (enrregB) outB <= bank[seloutB];
    end

    // ALUX model: done appears alu_delay cycles after start; 0 = never
    int            alu_delay = 2;
    int            alu_rem   = 0;
    logic [DW-1:0] alu_res   = '0;
    initial begin
        alu_done   = 1'b0;
        alu_result = '0;
    end
    always @(posedge clock) begin
        alu_done <= 1'b0;
        if (alu_start && alu_delay > 0) begin
            alu_rem = alu_delay;
            alu_res = ref_alu(alu_opr, alu_inA, alu_inB);
        end
        if (alu_rem > 0) begin
            alu_rem = alu_rem - 1;
            if (alu_rem == 0) begin
                alu_done   <= 1'b1;
                alu_result <= alu_res;
            end
        end
    end

    // Expected register contents
    logic [DW-1:0] ref_regs [16];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [DW-1:0] v);
        pl_en  = 1'b1;
        pl_idx = idx[RSW-1:0];
        pl_val = v;
        tick();
        pl_en  = 1'b0;
        ref_regs[idx] = v;
    endtask

    task automatic drive(input instr_t t);
        instr_opr   = t.opr;
        instr_srcA  = t.sa;
        instr_srcB  = t.sb;
        instr_dst   = t.dst;
        instr_wb    = t.wb;
        instr_cnstA = t.ca;
        instr_cnstB = t.cb;
        instr_endw  = ENDW_FULL;
    endtask

    task automatic check_idle_outputs(input string p);
        chk({p, "_ready"},     instr_ready, 1);
        chk({p, "_busy"},      busy, 0);
        chk({p, "_seloutA"},   seloutA, 0);
        chk({p, "_seloutB"},   seloutB, 0);
        chk({p, "_cnst"},      {cnstA, cnstB}, 0);
        chk({p, "_enrreg"},    {enrregA, enrregB}, 0);
        chk({p, "_regwen"},    regwen, 0);
        chk({p, "_selwreg"},   selwreg, 0);
        chk({p, "_endwreg"},   endwreg, 0);
        chk({p, "_wdata"},     wdata, 0);
        chk({p, "_alu_inA"},   alu_inA, 0);
        chk({p, "_alu_inB"},   alu_inB, 0);
        chk({p, "_alu_opr"},   alu_opr, 0);
        chk({p, "_alu_start"}, alu_start, 0);
        chk({p, "_res_valid"}, res_valid, 0);
        chk({p, "_res_data"},  res_data, 0);
        chk({p, "_err"},       err, 0);
    endtask

    // One full transaction with ALU delay d; cycle 0 is the accept edge.
    // With have_next the valid stays high and the next instruction is offered.
    task automatic run_instr(input string p, input instr_t t, input int d,
                             input bit have_next, input instr_t nx);
        logic [DW-1:0] ea, eb, er;
        bit            early;
        ea = ref_regs[t.sa];
        eb = ref_regs[t.sb];
        er = ref_alu(t.opr, ea, eb);
        alu_delay = d;
        drive(t);
        instr_valid = 1'b1;
        chk({p, "_ready_before"}, instr_ready, 1);
        tick();                                   // cycle 0
        if (have_next) drive(nx);
        else instr_valid = 1'b0;
        chk({p, "_busy_c0"}, {busy, instr_ready}, 2'b10);
        chk({p, "_sel_c0"}, {seloutA, seloutB}, {t.sa, t.sb});
        chk({p, "_cnst_c0"}, {cnstA, cnstB}, {t.ca, t.cb});
        chk({p, "_enr_c0"}, {enrregA, enrregB}, 2'b11);
        tick();                                   // cycle 1
        chk({p, "_enr_c1"}, {enrregA, enrregB}, 2'b00);
        tick();                                   // cycle 2
        chk({p, "_start_c2"}, alu_start, 0);
        tick();                                   // cycle 3
        chk({p, "_start_c3"}, alu_start, 1);
        chk({p, "_inA_c3"}, alu_inA, ea);
        chk({p, "_inB_c3"}, alu_inB, eb);
        chk({p, "_opr_c3"}, alu_opr, t.opr);
        early = 1'b0;
        for (int c = 4; c < 4 + d; c++) begin
            tick();
            if (res_valid || regwen || err || alu_start) early = 1'b1;
        end
        chk({p, "_no_early_event"}, early, 0);
        tick();                                   // cycle 4+d
        chk({p, "_res_valid"}, res_valid, 1);
        chk({p, "_res_data"}, res_data, er);
        chk({p, "_err_at_res"}, err, 0);
        chk({p, "_regwen"}, regwen, t.wb);
        if (t.wb) begin
            chk({p, "_selwreg"}, selwreg, t.dst);
            chk({p, "_wdata"}, wdata, er);
            chk({p, "_endwreg"}, endwreg, ENDW_FULL);
            ref_regs[t.dst] = er;
        end
        tick();                                   // cycle 5+d
        chk({p, "_pulse_end"}, {res_valid, regwen}, 2'b00);
        chk({p, "_ready_after"}, {instr_ready, busy}, 2'b10);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        instr_t        t, t2, none;
        logic [3:0]    oprs [4];
        logic [DW-1:0] r1;
        int            first_err, err_cnt;
        bit            rv_seen, rw_seen, busy_after, seen;

        oprs[0] = OPR_A;
        oprs[1] = OPR_B;
        oprs[2] = OPR_SUM;
        oprs[3] = OPR_SUB;
        none = '{opr: OPR_A, sa: '0, sb: '0, dst: '0, wb: 1'b0, ca: 1'b0, cb: 1'b0};

        reset       = 1'b0;
        instr_valid = 1'b0;
        drive(none);
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b1;

        for (int i = 0; i < 16; i++) preload(i, {$urandom, $urandom});

        // Sum: R3=5, R7=9, D=2 -> start cycle 3, result/regwen cycle 6
        preload(3, 64'd5);
        preload(7, 64'd9);
        t = '{opr: OPR_SUM, sa: 4'd3, sb: 4'd7, dst: 4'd1, wb: 1'b1, ca: 1'b0, cb: 1'b0};
        run_instr("sum", t, 2, 1'b0, none);
        chk("sum_bank_r1", bank[1], 64'd14);

        // Report only: 20-6 = 14, no write-back
        preload(3, 64'd20);
        preload(7, 64'd6);
        t = '{opr: OPR_SUB, sa: 4'd3, sb: 4'd7, dst: 4'd2, wb: 1'b0, ca: 1'b1, cb: 1'b0};
        run_instr("report", t, 3, 1'b0, none);

        // Timeout: start at cycle 3, err 64 cycles later at cycle 67
        alu_delay = 0;
        t = '{opr: OPR_SUM, sa: 4'd4, sb: 4'd5, dst: 4'd9, wb: 1'b1, ca: 1'b0, cb: 1'b0};
        drive(t);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        first_err = -1; err_cnt = 0; rv_seen = 0; rw_seen = 0; busy_after = 1;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (err) begin
                if (first_err < 0) first_err = c;
                err_cnt++;
            end
            if (res_valid) rv_seen = 1;
            if (regwen) rw_seen = 1;
            if (first_err > 0 && c == first_err + 1) busy_after = busy;
        end
        chk("timeout_err_cycle", first_err, 67);
        chk("timeout_err_pulse", err_cnt, 1);
        chk("timeout_no_res", rv_seen, 0);
        chk("timeout_no_regwen", rw_seen, 0);
        chk("timeout_busy_after", busy_after, 0);

        // Done on the very cycle the timer expires: done wins
        t = '{opr: OPR_SUB, sa: 4'd10, sb: 4'd11, dst: 4'd12, wb: 1'b1, ca: 1'b0, cb: 1'b1};
        run_instr("simul", t, TIMEOUT - 1, 1'b0, none);

        // Reset during WAIT, done arrives later and must be ignored
        alu_delay = 10;
        t = '{opr: OPR_SUM, sa: 4'd1, sb: 4'd2, dst: 4'd9, wb: 1'b1, ca: 1'b1, cb: 1'b1};
        drive(t);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        tick();
        check_idle_outputs("midrst");
        reset = 1'b1;
        seen = 0;
        repeat (15) begin
            tick();
            if (res_valid || regwen || err || busy) seen = 1;
        end
        chk("midrst_done_ignored", seen, 0);

        // Back-to-back: second instruction reads the first's destination
        t  = '{opr: OPR_SUM, sa: 4'd4, sb: 4'd5, dst: 4'd6, wb: 1'b1, ca: 1'b0, cb: 1'b0};
        t2 = '{opr: OPR_A,   sa: 4'd6, sb: 4'd0, dst: 4'd8, wb: 1'b1, ca: 1'b0, cb: 1'b0};
        r1 = ref_alu(OPR_SUM, ref_regs[4], ref_regs[5]);
        run_instr("b2b1", t, 1, 1'b1, t2);
        run_instr("b2b2", t2, 2, 1'b0, none);
        chk("b2b_inA_first_result", alu_inA, r1);

        // Randomised transactions
        for (int n = 0; n < 10; n++) begin
            preload($urandom_range(0, 15), {$urandom, $urandom});
            t.opr = oprs[$urandom_range(0, 3)];
            t.sa  = RSW'($urandom_range(0, 15));
            t.sb  = RSW'($urandom_range(0, 15));
            t.dst = RSW'($urandom_range(0, 15));
            t.wb  = 1'($urandom_range(0, 1));
            t.ca  = 1'($urandom_range(0, 1));
            t.cb  = 1'($urandom_range(0, 1));
            run_instr($sformatf("rand%0d", n), t, $urandom_range(1, 6), 1'b0, none);
        end

        for (int i = 0; i < 16; i++) chk($sformatf("bank_final_r%0d", i), bank[i], ref_regs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator-side controller for the register-bank / ALUX datapath.
- Accepts one register-to-register instruction at a time and drives the full sequence:
  - drives the reg_bank read selects and latches operands;
  - pulses ALUX start and waits for done;
  - writes the result back through the reg_bank write port.
- Replaces bench-driven sequencing and sits between the instruction source and reg_bank/ALUX.

Parameters:
- DW, 64, datapath width (reg_bank and ALUX word size)
- RSW, 4, register select width (16 registers)
- TIMEOUT, 64, maximum cycles to wait for alu_done before aborting

Ports:
- clock  in  1  single system clock, all logic on posedge
- reset  in  1  synchronous, active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept (high only in IDLE)
- instr_opr  in  4  ALUX opcode (0000=A, 0001=B, 0010=sum, 0011=sub, ...)
- instr_srcA  in  RSW  register read on port A
- instr_srcB  in  RSW  register read on port B
- instr_dst  in  RSW  destination register
- instr_cnstA  in  1  forwarded to reg_bank cnstA
- instr_cnstB  in  1  forwarded to reg_bank cnstB
- instr_wb  in  1  1 = write the result back; 0 = report only
- instr_endw  in  2  forwarded to reg_bank endwreg (00 = full word)
- seloutA  out  RSW  reg_bank read select A
- seloutB  out  RSW  reg_bank read select B
- cnstA  out  1  reg_bank constant select A
- cnstB  out  1  reg_bank constant select B
- enrregA  out  1  reg_bank output-register enable A
- enrregB  out  1  reg_bank output-register enable B
- outA  in  DW  reg_bank read data A
- outB  in  DW  reg_bank read data B
- regwen  out  1  reg_bank write enable
- selwreg  out  RSW  reg_bank write select
- endwreg  out  2  reg_bank write mode
- wdata  out  DW  reg_bank write data (to reg_bank inA)
- alu_inA  out  DW  ALUX operand A
- alu_inB  out  DW  ALUX operand B
- alu_opr  out  4  ALUX opcode
- alu_start  out  1  ALUX start, one-cycle pulse
- alu_result  in  DW  ALUX outAB
- alu_done  in  1  ALUX done
- res_valid  out  1  one-cycle pulse, result available
- res_data  out  DW  result, held until the next res_valid
- err  out  1  one-cycle pulse on ALU timeout
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE;
  - regwen, alu_start, enrregA, enrregB, res_valid, err = 0;
  - all select, data and operand registers = 0;
  - endwreg=00.
- Reset asserted in any state aborts the operation with no write-back.
- All outputs are registered.
- Handshake: an instruction is accepted on the posedge where instr_valid and instr_ready are both 1. Its fields are captured into internal registers; inputs may then change freely.
- States:
  - IDLE: instr_ready=1. On accept, go to READ.
  - READ (1 cycle):
    - seloutA=srcA, seloutB=srcB, cnstA/cnstB from the captured instruction, enrregA=enrregB=1;
    - go to LATCH.
  - LATCH (1 cycle):
    - enrregA=enrregB=0;
    - capture outA/outB into alu_inA/alu_inB (reg_bank read latency is 1 cycle);
    - go to EXEC.
  - EXEC (1 cycle):
    - alu_start=1, alu_opr=captured opr;
    - clear the timeout counter;
    - go to WAIT.
  - WAIT:
    - alu_start=0; alu_inA, alu_inB and alu_opr held stable;
    - alu_done is ignored during EXEC and sampled only in WAIT;
    - alu_done=1: capture alu_result into res_data, res_valid=1 next cycle; go to WB if wb=1, else IDLE;
    - counter reaching TIMEOUT-1 without done: err=1, no res_valid, no write, go to IDLE;
    - if done and timeout coincide, done wins.
  - WB (1 cycle):
    - regwen=1, selwreg=dst, wdata=res_data, endwreg=endw;
    - go to IDLE; regwen returns to 0 the next cycle.
- Latency with ALU done D≥1 cycles after start:
  - accept edge = cycle 0, alu_start at cycle 3, res_valid at cycle 4+D;
  - regwen at cycle 4+D, coinciding with res_valid; next accept no earlier than cycle 5+D.
- dst equal to srcA or srcB is legal; the operands are already latched, so no hazard.
- Widths: no arithmetic is done in this block; the opcode passes through unchanged. The timeout counter is $clog2(TIMEOUT) bits.

Decomposition:
- Shared package alu_seq_pkg:
  - state encoding (IDLE, READ, LATCH, EXEC, WAIT, WB);
  - ALUX opcode constants (OPR_A=0000, OPR_B=0001, OPR_SUM=0010, OPR_SUB=0011);
  - ENDW_FULL=00.
- Single module otherwise.
- One natural sub-module: alu_seq_timeout, a loadable down-counter with an expiry flag.

Test Plan:
- Sum:
  - stimulus: bench reg_bank model R3=5, R7=9; ALU model D=2; issue opr=0010, srcA=3, srcB=7, dst=1, wb=1;
  - required: alu_start at cycle 3 with alu_inA=5, alu_inB=9; res_valid and regwen at cycle 6 with selwreg=1, wdata=14; instr_ready=1 at cycle 7.
- Report only:
  - stimulus: opr=0011, R3=20, R7=6, wb=0;
  - required: res_data=14, res_valid pulse, regwen never asserts.
- Timeout:
  - stimulus: ALU model never raises done, TIMEOUT=64;
  - required: err pulse exactly 64 cycles after the EXEC cycle, no regwen, busy=0 next cycle.
- Reset mid-operation:
  - stimulus: drive reset=0 for one edge during WAIT, then release;
  - required: all outputs 0, instr_ready=1, and a later done pulse is ignored.
- Back-to-back:
  - stimulus: instr_valid held high with two instructions; the second reads the first's dst;
  - required: the second is accepted the cycle after the first's WB and alu_inA equals the first result.
- Simultaneous events:
  - stimulus: done on the same cycle as timeout expiry;
  - required: res_valid=1, err=0.
